bram_port_arbiter: RTL
======================

# bram_port_arbiter

Round-robin arbiter sharing one dual-port block RAM (one write port, one synchronous-read port) among NUM_REQ requesters. Read and write channels are arbitrated independently, so one write and one read can be granted per cycle. Read data returns one cycle after grant, tagged with the requester. Sits between the requesting engines and the dual-port BRAM instance.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 36, data width; must match the RAM
- LOG_DEP, 6, address width; must match the RAM

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_req  in  NUM_REQ  per-requester write request; held until granted
- wr_addr  in  NUM_REQ*LOG_DEP  packed write addresses, requester i at slice i
- wr_data  in  NUM_REQ*WIDTH  packed write data
- wr_gnt  out  NUM_REQ  one-hot write grant; write is committed that cycle
- rd_req  in  NUM_REQ  per-requester read request; held until granted
- rd_addr  in  NUM_REQ*LOG_DEP  packed read addresses
- rd_gnt  out  NUM_REQ  one-hot read grant
- rd_valid  out  NUM_REQ  one-hot; data for that requester on rd_data
- rd_data  out  WIDTH  read return data
- ram_enable  out  1  to RAM enable
- ram_wen  out  1  to RAM write enable
- ram_waddr  out  LOG_DEP  to RAM write address
- ram_raddr  out  LOG_DEP  to RAM read address
- ram_din  out  WIDTH  to RAM write data
- ram_dout  in  WIDTH  from RAM read data (valid one cycle after raddr is sampled)

## Operation
- Two identical round-robin arbiters: write and read. Each holds a pointer (index of last grant, reset NUM_REQ-1). Search starts at pointer+1, wraps modulo NUM_REQ. Pointer updates only on a grant.
- wr_gnt, rd_gnt are combinational from requests and pointer; at most one bit set each. A held request with no grant must not change address or data.
- Write channel: ram_wen = |wr_gnt; ram_waddr/ram_din muxed from granted requester (0 when none).
- Read channel: ram_raddr muxed from granted requester (holds last value when none). A one-hot register rd_pend <= rd_gnt; rd_valid = rd_pend; rd_data = ram_dout.
- ram_enable = |wr_gnt | |rd_gnt.
- Same-address write and read in one cycle: RAM returns the old contents (read-first). This is the required behaviour unless the bypass feature is compiled in.
- Requester may be granted read and write in the same cycle.
- A requester that drops its request before grant is legal; no grant is issued to it.

## Timing
- Grant: same cycle as request (0-cycle arbitration latency).
- Read latency: rd_valid/rd_data exactly 1 cycle after rd_gnt; back-to-back reads give one result per cycle.
- Throughput: 1 write + 1 read per cycle sustained.
- Reset (async assert, sync release): pointers = NUM_REQ-1, rd_pend = 0, rd_valid = 0, ram_raddr register = 0. All grants 0 while reset_n low. A read granted in the cycle reset asserts produces no rd_valid.
- Fairness: with all NUM_REQ requesting continuously, each granted once per NUM_REQ cycles per channel.

## Configuration
- BRAM_ARB_BYPASS_EN defined: register the write address/data and a hit flag when a read and write are granted to the same address in one cycle; next cycle rd_data returns the written data instead of ram_dout (write-first semantics). Adds one WIDTH-bit register.
- Undefined: no forwarding; rd_data is always ram_dout (read-first).

## Structure
- Package bram_arb_pkg: default NUM_REQ/WIDTH/LOG_DEP constants, a function returning one-hot-to-index conversion, and the idx width constant clog2(NUM_REQ).
- One sub-module rr_arbiter (parameter N; ports clock, reset_n, req, gnt), instantiated once for writes and once for reads.

## Test plan
- Reset: reset_n low with all requests high -> all grants 0, rd_valid 0; after release first grant goes to requester 0 on both channels.
- Fairness: all 4 write requests held 8 cycles -> wr_gnt sequence 0,1,2,3,0,1,2,3.
- Read latency: requester 2 writes 0xA5 to addr 5, next cycle reads addr 5 -> rd_valid = 4'b0100 one cycle after rd_gnt, rd_data = 0xA5.
- Concurrency: requester 1 writes addr 3 while requester 3 reads addr 7 same cycle -> both granted, requester 3 receives prior addr-7 contents.
- Same-address collision: addr 9 holds 0x11; write 0x22 and read addr 9 same cycle -> rd_data 0x11 without BRAM_ARB_BYPASS_EN, 0x22 with it.
- Reset mid-operation: assert reset_n low the cycle after rd_gnt -> rd_valid drops to 0 immediately, pointers return to NUM_REQ-1.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared constants and helpers for the BRAM port arbiter.
// Defaults for requester count, data width and address width.
package bram_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int WIDTH_DEF   = 36;
    localparam int LOG_DEP_DEF = 6;
    localparam int IDX_W       = $clog2(NUM_REQ_DEF);

    // Up to eight requesters are supported, so a 3-bit index always suffices.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = idx | (oh[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-channel round-robin arbiter: combinational one-hot grant,
// pointer remembers the last winner and moves only when a grant is issued.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_r;
    logic [IW-1:0] idx_s;
    logic          found_s;
    logic [N-1:0]  gnt_s;

    // Rotating priority search starting just after the last winner
    always_comb begin
        gnt_s   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 1; k <= N; k++) begin
            idx_s        = IW'((int'(ptr_r) + k) % N);
            gnt_s[idx_s] = req[idx_s] & ~found_s & reset_n;
            found_s      = found_s | req[idx_s];
        end
    end

    assign gnt = gnt_s;

    // Last-winner pointer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r <= IW'(N - 1);
        end else if (|gnt_s) begin
            ptr_r <= IW'(onehot_to_idx(8'(gnt_s)));
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one write port and one synchronous-read port of a BRAM among NUM_REQ
// requesters. Optional write-to-read forwarding under BRAM_ARB_BYPASS_EN.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int LOG_DEP = LOG_DEP_DEF
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         wr_req,
    input  logic [NUM_REQ*LOG_DEP-1:0] wr_addr,
    input  logic [NUM_REQ*WIDTH-1:0]   wr_data,
    output logic [NUM_REQ-1:0]         wr_gnt,
    input  logic [NUM_REQ-1:0]         rd_req,
    input  logic [NUM_REQ*LOG_DEP-1:0] rd_addr,
    output logic [NUM_REQ-1:0]         rd_gnt,
    output logic [NUM_REQ-1:0]         rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       ram_enable,
    output logic                       ram_wen,
    output logic [LOG_DEP-1:0]         ram_waddr,
    output logic [LOG_DEP-1:0]         ram_raddr,
    output logic [WIDTH-1:0]           ram_din,
    input  logic [WIDTH-1:0]           ram_dout
);

    logic [LOG_DEP-1:0] waddr_s;
    logic [WIDTH-1:0]   din_s;
    logic [LOG_DEP-1:0] raddr_sel_s;
    logic [LOG_DEP-1:0] raddr_hold_r;
    logic [NUM_REQ-1:0] rd_pend_r;

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (wr_req),
        .gnt     (wr_gnt)
    );

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (rd_req),
        .gnt     (rd_gnt)
    );

    // AND-OR muxes selecting the granted requester's address and data
    always_comb begin
        waddr_s     = '0;
        din_s       = '0;
        raddr_sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            waddr_s     = waddr_s | (wr_addr[i*LOG_DEP +: LOG_DEP] & {LOG_DEP{wr_gnt[i]}});
            din_s       = din_s | (wr_data[i*WIDTH +: WIDTH] & {WIDTH{wr_gnt[i]}});
            raddr_sel_s = raddr_sel_s | (rd_addr[i*LOG_DEP +: LOG_DEP] & {LOG_DEP{rd_gnt[i]}});
        end
    end

    assign ram_wen    = |wr_gnt;
    assign ram_enable = (|wr_gnt) | (|rd_gnt);
    assign ram_waddr  = waddr_s;
    assign ram_din    = din_s;
    assign ram_raddr  = (|rd_gnt) ? raddr_sel_s : raddr_hold_r;
    assign rd_valid   = rd_pend_r;

    // Read-address hold and one-cycle read-return tag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            raddr_hold_r <= '0;
            rd_pend_r    <= '0;
        end else begin
            raddr_hold_r <= ram_raddr;
            rd_pend_r    <= rd_gnt;
        end
    end

`ifdef BRAM_ARB_BYPASS_EN
    logic             hit_r;
    logic [WIDTH-1:0] byp_data_r;

    // Capture write data when a same-cycle read targets the written address
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_r      <= 1'b0;
            byp_data_r <= '0;
        end else begin
            hit_r      <= (|wr_gnt) & (|rd_gnt) & (waddr_s == raddr_sel_s);
            byp_data_r <= din_s;
        end
    end

    assign rd_data = hit_r ? byp_data_r : ram_dout;
`else
    assign rd_data = ram_dout;
`endif

endmodule
